mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 14 +
 rtl/mem_ctrl.sv | 89 ++++++++
 tb/tb_mem_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the datapath memory controller.
// Address 16'hFFFF is the memory-mapped switch/display port.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [15:0] IO_ADDR = 16'hFFFF;
  localparam int          CNT_W   = 4;

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller between the datapath and an async SRAM, with a
// memory-mapped switch input / hex display register at IO_ADDR.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset_al,
  input  logic        MEM_REQ,
  input  logic        MEM_WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic [15:0] SW,
  input  logic [15:0] Data_from_SRAM,
  output logic [15:0] MDR_In,
  output logic        MEM_R,
  output logic [19:0] SRAM_ADDR,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic [15:0] Data_to_SRAM,
  output logic [15:0] HEX_DATA
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      addr_q;
  logic [15:0]      data_q;
  logic             we_q;

  logic is_io;
  logic in_access;
  logic sram_sel;

  assign is_io     = (addr_q == IO_ADDR);
  assign in_access = (state == ACCESS);
  assign sram_sel  = in_access && !is_io;

  // Everything below decodes only registered state, so the SRAM pins
  // never glitch with datapath inputs.
  assign MEM_R        = (state == DONE);
  assign SRAM_CE_N    = !sram_sel;
  assign SRAM_OE_N    = !(sram_sel && !we_q);
  assign SRAM_WE_N    = !(sram_sel && we_q);
  assign SRAM_ADDR    = {4'b0, addr_q};
  assign Data_to_SRAM = data_q;

  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      MDR_In   <= '0;
      HEX_DATA <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MEM_REQ) begin
            addr_q <= MAR;
            data_q <= MDR;
            we_q   <= MEM_WE;
            cnt    <= CNT_INIT;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state <= DONE;
            // Completion side effects land on the ACCESS-exit edge.
            if (!we_q)
              MDR_In <= is_io ? SW : Data_from_SRAM;
            else if (is_io)
              HEX_DATA <= data_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: SRAM/IO reads and writes, back-to-back
// requests, reset mid-access and WAIT_CYCLES = 1 / 15 latency.
module tb_mem_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_al;
  logic        req, we, req1, req15;
  logic [15:0] mar, mdr, sw, sram_d;

  logic [15:0] mdr_in, hex, d2s;
  logic        mem_r, ce_n, oe_n, we_n;
  logic [19:0] saddr;

  logic [15:0] mdr_in1, hex1, d2s1, mdr_in15, hex15, d2s15;
  logic        mem_r1, ce_n1, oe_n1, we_n1, mem_r15, ce_n15, oe_n15, we_n15;
  logic [19:0] saddr1, saddr15;

  int n_pass = 0;
  int n_total = 0;

  always #5 Clk = ~Clk;

  mem_ctrl #(.WAIT_CYCLES(2)) u_dut (
    .Clk(Clk), .Reset_al(Reset_al), .MEM_REQ(req), .MEM_WE(we), .MAR(mar), .MDR(mdr),
    .SW(sw), .Data_from_SRAM(sram_d), .MDR_In(mdr_in), .MEM_R(mem_r), .SRAM_ADDR(saddr),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .Data_to_SRAM(d2s), .HEX_DATA(hex));

  mem_ctrl #(.WAIT_CYCLES(1)) u_w1 (
    .Clk(Clk), .Reset_al(Reset_al), .MEM_REQ(req1), .MEM_WE(1'b0), .MAR(mar), .MDR(mdr),
    .SW(sw), .Data_from_SRAM(sram_d), .MDR_In(mdr_in1), .MEM_R(mem_r1), .SRAM_ADDR(saddr1),
    .SRAM_CE_N(ce_n1), .SRAM_OE_N(oe_n1), .SRAM_WE_N(we_n1), .Data_to_SRAM(d2s1), .HEX_DATA(hex1));

  mem_ctrl #(.WAIT_CYCLES(15)) u_w15 (
    .Clk(Clk), .Reset_al(Reset_al), .MEM_REQ(req15), .MEM_WE(1'b0), .MAR(mar), .MDR(mdr),
    .SW(sw), .Data_from_SRAM(sram_d), .MDR_In(mdr_in15), .MEM_R(mem_r15), .SRAM_ADDR(saddr15),
    .SRAM_CE_N(ce_n15), .SRAM_OE_N(oe_n15), .SRAM_WE_N(we_n15), .Data_to_SRAM(d2s15), .HEX_DATA(hex15));

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset_al = 1'b0;
    req = 0; we = 0; req1 = 0; req15 = 0;
    mar = 16'h0; mdr = 16'h0; sw = 16'h0; sram_d = 16'h0;
    repeat (2) tick();
    n_total++; if ({mem_r, ce_n, oe_n, we_n} !== 4'b0111) $display("FAIL reset_ctrl got %b exp 0111", {mem_r, ce_n, oe_n, we_n}); else n_pass++;
    n_total++; if ({mdr_in, hex, d2s} !== 48'h0) $display("FAIL reset_data got %h exp 0", {mdr_in, hex, d2s}); else n_pass++;
    n_total++; if (saddr !== 20'h0) $display("FAIL reset_addr got %h exp 00000", saddr); else n_pass++;
    Reset_al = 1'b1;
    tick();
  endtask

  task automatic test_sram_read();
    mar = 16'h0003; sram_d = 16'hBEEF; req = 1; we = 0;
    tick();                       // edge 1 samples request
    req = 0; mar = 16'h0777;      // late MAR change must be ignored
    for (int e = 2; e <= 3; e++) begin
      n_total++; if ({mem_r, ce_n, oe_n, we_n} !== 4'b0001) $display("FAIL rd_strobe e%0d got %b exp 0001", e - 1, {mem_r, ce_n, oe_n, we_n}); else n_pass++;
      n_total++; if (saddr !== 20'h00003) $display("FAIL rd_addr e%0d got %h exp 00003", e - 1, saddr); else n_pass++;
      tick();
    end
    n_total++; if ({mem_r, ce_n, oe_n, we_n} !== 4'b1111) $display("FAIL rd_done got %b exp 1111", {mem_r, ce_n, oe_n, we_n}); else n_pass++;
    n_total++; if (mdr_in !== 16'hBEEF) $display("FAIL rd_data got %h exp BEEF", mdr_in); else n_pass++;
    tick();
    n_total++; if (mem_r !== 1'b0) $display("FAIL rd_pulse_end got %b exp 0", mem_r); else n_pass++;
  endtask

  task automatic test_sram_write();
    mar = 16'h0010; mdr = 16'h1234; req = 1; we = 1;
    tick();
    req = 0; we = 0; mdr = 16'hFFFF;
    for (int e = 1; e <= 2; e++) begin
      n_total++; if ({mem_r, ce_n, oe_n, we_n} !== 4'b0010) $display("FAIL wr_strobe c%0d got %b exp 0010", e, {mem_r, ce_n, oe_n, we_n}); else n_pass++;
      n_total++; if ({saddr, d2s} !== {20'h00010, 16'h1234}) $display("FAIL wr_bus c%0d got %h exp 000101234", e, {saddr, d2s}); else n_pass++;
      tick();
    end
    n_total++; if ({mem_r, ce_n, oe_n, we_n} !== 4'b1111) $display("FAIL wr_done got %b exp 1111", {mem_r, ce_n, oe_n, we_n}); else n_pass++;
    n_total++; if ({mdr_in, hex} !== {16'hBEEF, 16'h0000}) $display("FAIL wr_hold got %h exp BEEF0000", {mdr_in, hex}); else n_pass++;
    tick();
  endtask

  task automatic test_io();
    mar = 16'hFFFF; mdr = 16'h00A5; req = 1; we = 1;
    tick();
    req = 0; we = 0;
    for (int e = 1; e <= 2; e++) begin
      n_total++; if ({mem_r, ce_n, oe_n, we_n} !== 4'b0111) $display("FAIL iow_strobe c%0d got %b exp 0111", e, {mem_r, ce_n, oe_n, we_n}); else n_pass++;
      tick();
    end
    n_total++; if (mem_r !== 1'b1) $display("FAIL iow_ready got %b exp 1", mem_r); else n_pass++;
    n_total++; if ({hex, mdr_in} !== {16'h00A5, 16'hBEEF}) $display("FAIL iow_hex got %h exp 00A5BEEF", {hex, mdr_in}); else n_pass++;
    tick();
    sw = 16'h5A5A; req = 1; we = 0;
    tick();
    req = 0;
    for (int e = 1; e <= 2; e++) begin
      n_total++; if ({mem_r, ce_n, oe_n, we_n} !== 4'b0111) $display("FAIL ior_strobe c%0d got %b exp 0111", e, {mem_r, ce_n, oe_n, we_n}); else n_pass++;
      tick();
    end
    n_total++; if (mem_r !== 1'b1) $display("FAIL ior_ready got %b exp 1", mem_r); else n_pass++;
    n_total++; if ({mdr_in, hex} !== {16'h5A5A, 16'h00A5}) $display("FAIL ior_data got %h exp 5A5A00A5", {mdr_in, hex}); else n_pass++;
    tick();
  endtask

  // Request held for 10 edges: samples at edges 1,5,9; MEM_R after edges 3,7,11.
  task automatic test_back_to_back();
    logic [15:0] exp_addr;
    sram_d = 16'hC0DE; we = 0; req = 1; mar = 16'h0101;
    for (int i = 1; i <= 12; i++) begin
      tick();
      n_total++; if (mem_r !== ((i % 4) == 3)) $display("FAIL b2b_ready e%0d got %b exp %b", i, mem_r, (i % 4) == 3); else n_pass++;
      if ((i % 4) == 1 || (i % 4) == 2) begin
        exp_addr = 16'h0100 + 16'(i - ((i - 1) % 4));
        n_total++; if (saddr !== {4'b0, exp_addr}) $display("FAIL b2b_addr e%0d got %h exp %h", i, saddr, {4'b0, exp_addr}); else n_pass++;
      end
      mar = 16'h0100 + 16'(i + 1);
      if (i == 10) req = 0;
    end
    n_total++; if (mdr_in !== 16'hC0DE) $display("FAIL b2b_data got %h exp C0DE", mdr_in); else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    mar = 16'h0005; sram_d = 16'h9999; req = 1; we = 0;
    tick();
    req = 0;
    n_total++; if ({ce_n, oe_n} !== 2'b00) $display("FAIL rst_pre got %b exp 00", {ce_n, oe_n}); else n_pass++;
    Reset_al = 1'b0;
    #1;
    n_total++; if ({mem_r, ce_n, oe_n, we_n} !== 4'b0111) $display("FAIL rst_abort got %b exp 0111", {mem_r, ce_n, oe_n, we_n}); else n_pass++;
    n_total++; if ({mdr_in, hex} !== 32'h0) $display("FAIL rst_clear got %h exp 0", {mdr_in, hex}); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (mem_r !== 1'b0) $display("FAIL rst_noready c%0d got %b exp 0", i, mem_r); else n_pass++;
    end
    mar = 16'h0006; sram_d = 16'h4321; req = 1;
    #2 Reset_al = 1'b1;           // released mid-cycle; next edge samples req
    tick();
    req = 0;
    n_total++; if ({ce_n, oe_n, saddr} !== {2'b00, 20'h00006}) $display("FAIL rst_restart got %h exp 000006", {ce_n, oe_n, saddr}); else n_pass++;
    repeat (2) tick();
    n_total++; if ({mem_r, mdr_in} !== {1'b1, 16'h4321}) $display("FAIL rst_next got %h exp 14321", {mem_r, mdr_in}); else n_pass++;
    tick();
  endtask

  task automatic test_wait_sweep();
    int n;
    mar = 16'h0020; sram_d = 16'h1111;
    req1 = 1; n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      req1 = 0;
      if (mem_r1) begin n = i; break; end
    end
    n_total++; if (n != 2) $display("FAIL w1_latency got %0d exp 2", n); else n_pass++;
    n_total++; if (mdr_in1 !== 16'h1111) $display("FAIL w1_data got %h exp 1111", mdr_in1); else n_pass++;
    tick();
    sram_d = 16'h2222;
    req15 = 1; n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      req15 = 0;
      if (i == 15) begin
        n_total++; if ({ce_n15, oe_n15} !== 2'b00) $display("FAIL w15_last_access got %b exp 00", {ce_n15, oe_n15}); else n_pass++;
      end
      if (mem_r15) begin n = i; break; end
    end
    n_total++; if (n != 16) $display("FAIL w15_latency got %0d exp 16", n); else n_pass++;
    n_total++; if (mdr_in15 !== 16'h2222) $display("FAIL w15_data got %h exp 2222", mdr_in15); else n_pass++;
    tick();
    n_total++; if (mem_r15 !== 1'b0) $display("FAIL w15_pulse_end got %b exp 0", mem_r15); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sram_read();
    test_sram_write();
    test_io();
    test_back_to_back();
    test_reset_mid_access();
    test_wait_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
